// File: rtl/stage5_controller_if.sv
// stage5_controller_if
// Purpose: groups the stage-5 controller's datapath-facing signals into a
// single bundle. Clock and reset stay as plain ports on the controller.
// Signals:
//   Run, Opcode[3:0], AZero           -- status from datapath into controller
//   PCWrite, PCSource, PCAdd          -- PC unit control
//   MSPWrite, MSPPop, RSPWrite, RSPPop -- stack pointer control (Pop=0 grows)
//   ValAWrite, ValBWrite, IRWrite     -- register load enables
//   MemRead1/2, MemWrite1/2           -- memory strobes
//   MemDst1[1:0] (0=PC,1=MSP), MemDst2[1:0] (0=MSP,1=RSP)
//   MemData[2:0] (0=PC,1=Res,2=ZEImm) -- write data select
//   InstrDone, Halted                 -- instruction completion / halt status
// Modports: master = controller side, slave = datapath side.
interface stage5_controller_if;
    logic       Run;
    logic [3:0] Opcode;
    logic       AZero;
    logic       PCWrite;
    logic       PCSource;
    logic       PCAdd;
    logic       MSPWrite;
    logic       MSPPop;
    logic       RSPWrite;
    logic       RSPPop;
    logic       ValAWrite;
    logic       ValBWrite;
    logic       IRWrite;
    logic       MemRead1;
    logic       MemRead2;
    logic       MemWrite1;
    logic       MemWrite2;
    logic [1:0] MemDst1;
    logic [1:0] MemDst2;
    logic [2:0] MemData;
    logic       InstrDone;
    logic       Halted;

    modport master (
        input  Run, Opcode, AZero,
        output PCWrite, PCSource, PCAdd,
        output MSPWrite, MSPPop, RSPWrite, RSPPop,
        output ValAWrite, ValBWrite, IRWrite,
        output MemRead1, MemRead2, MemWrite1, MemWrite2,
        output MemDst1, MemDst2, MemData,
        output InstrDone, Halted
    );

    modport slave (
        output Run, Opcode, AZero,
        input  PCWrite, PCSource, PCAdd,
        input  MSPWrite, MSPPop, RSPWrite, RSPPop,
        input  ValAWrite, ValBWrite, IRWrite,
        input  MemRead1, MemRead2, MemWrite1, MemWrite2,
        input  MemDst1, MemDst2, MemData,
        input  InstrDone, Halted
    );
endinterface

// File: rtl/stage5_controller.sv
// stage5_controller
// Purpose: multi-cycle control FSM for a small two-stack machine. Sequences
// fetch, decode and the per-opcode micro-steps, driving datapath strobes.
// Ports:
//   CLK    -- single clock, rising edge
//   RST_N  -- asynchronous active-low reset; forces FETCH and zeroes outputs
//   bus    -- stage5_controller_if.master (Run/Opcode/AZero in, controls out)
//
// State  | Meaning
// FETCH  | read instruction at PC, load IR, increment PC (only when Run=1)
// DECODE | dispatch on Opcode; NOP completes here
// RDA    | read stack top into ValA; POP completes here
// POPB   | pop MSP for the second ALU operand
// RDB    | read stack top into ValB
// WRES   | write ALU result at MSP
// PUSH   | grow MSP; completes PUSHI and ALU
// JMPA   | load PC from ValA; completes JMP, CALL, RET
// BR     | conditional PC-relative branch on AZero; completes BRZ
// RSW    | write return address (PC) onto the return stack
// RSINC  | grow RSP after the return-address write
// RSPOP  | settle cycle after the RSP pop, before reading the return stack
// RDRS   | read return address into ValA
// HALT   | stopped until reset
module stage5_controller (
    input  logic                CLK,
    input  logic                RST_N,
    stage5_controller_if.master bus
);

    typedef enum logic [3:0] {
        FETCH, DECODE, RDA, POPB, RDB, WRES, PUSH,
        JMPA, BR, RSW, RSINC, RSPOP, RDRS, HALT
    } state_t;

    localparam logic [3:0] OP_PUSHI = 4'h1;
    localparam logic [3:0] OP_POP   = 4'h2;
    localparam logic [3:0] OP_ALU   = 4'h3;
    localparam logic [3:0] OP_JMP   = 4'h4;
    localparam logic [3:0] OP_BRZ   = 4'h5;
    localparam logic [3:0] OP_CALL  = 4'h6;
    localparam logic [3:0] OP_RET   = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t state, nextState;

    logic       pcWrite, pcSource, pcAdd;
    logic       mspWrite, mspPop, rspWrite, rspPop;
    logic       valAWrite, valBWrite, irWrite;
    logic       memRead1, memRead2, memWrite1, memWrite2;
    logic [1:0] memDst1, memDst2;
    logic [2:0] memData;
    logic       instrDone, halted;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        pcWrite   = 1'b0;
        pcSource  = 1'b0;
        pcAdd     = 1'b0;
        mspWrite  = 1'b0;
        mspPop    = 1'b0;
        rspWrite  = 1'b0;
        rspPop    = 1'b0;
        valAWrite = 1'b0;
        valBWrite = 1'b0;
        irWrite   = 1'b0;
        memRead1  = 1'b0;
        memRead2  = 1'b0;
        memWrite1 = 1'b0;
        memWrite2 = 1'b0;
        memDst1   = 2'd0;
        memDst2   = 2'd0;
        memData   = 3'd0;
        instrDone = 1'b0;
        halted    = 1'b0;

        case (state)
            FETCH: begin
                // Run is consulted only here; an idle FETCH must not load IR
                // or bump the PC, so the fetch strobes are qualified by Run.
                if (bus.Run) begin
                    memRead1  = 1'b1;
                    irWrite   = 1'b1;
                    pcWrite   = 1'b1;
                    nextState = DECODE;
                end
            end
            DECODE: begin
                case (bus.Opcode)
                    OP_PUSHI: begin
                        memWrite2 = 1'b1;
                        memData   = 3'd2;
                        nextState = PUSH;
                    end
                    OP_POP, OP_ALU, OP_JMP, OP_BRZ, OP_CALL: begin
                        mspWrite  = 1'b1;
                        mspPop    = 1'b1;
                        nextState = RDA;
                    end
                    OP_RET: begin
                        rspWrite  = 1'b1;
                        rspPop    = 1'b1;
                        nextState = RSPOP;
                    end
                    OP_HALT: nextState = HALT;
                    default: begin
                        instrDone = 1'b1;
                        nextState = FETCH;
                    end
                endcase
            end
            RDA: begin
                memRead2  = 1'b1;
                valAWrite = 1'b1;
                case (bus.Opcode)
                    OP_ALU:  nextState = POPB;
                    OP_JMP:  nextState = JMPA;
                    OP_BRZ:  nextState = BR;
                    OP_CALL: nextState = RSW;
                    // POP ends here; an opcode that changed underneath us is
                    // retired the same way so every instruction still completes.
                    default: begin
                        instrDone = 1'b1;
                        nextState = FETCH;
                    end
                endcase
            end
            POPB: begin
                mspWrite  = 1'b1;
                mspPop    = 1'b1;
                nextState = RDB;
            end
            RDB: begin
                memRead2  = 1'b1;
                valBWrite = 1'b1;
                nextState = WRES;
            end
            WRES: begin
                memWrite2 = 1'b1;
                memData   = 3'd1;
                nextState = PUSH;
            end
            PUSH: begin
                mspWrite  = 1'b1;
                instrDone = 1'b1;
                nextState = FETCH;
            end
            BR: begin
                if (bus.AZero) begin
                    pcWrite = 1'b1;
                    pcAdd   = 1'b1;
                end
                instrDone = 1'b1;
                nextState = FETCH;
            end
            RSW: begin
                memWrite2 = 1'b1;
                memDst2   = 2'd1;
                nextState = RSINC;
            end
            RSINC: begin
                rspWrite  = 1'b1;
                nextState = JMPA;
            end
            RSPOP: nextState = RDRS;
            RDRS: begin
                memRead2  = 1'b1;
                memDst2   = 2'd1;
                valAWrite = 1'b1;
                nextState = JMPA;
            end
            JMPA: begin
                pcWrite   = 1'b1;
                pcSource  = 1'b1;
                instrDone = 1'b1;
                nextState = FETCH;
            end
            HALT: begin
                halted    = 1'b1;
                nextState = HALT;
            end
            default: nextState = FETCH;
        endcase
    end

    // Reset blanks every output immediately, even the Run-qualified fetch
    // strobes that FETCH (the reset state) would otherwise present.
    assign bus.PCWrite   = pcWrite   & RST_N;
    assign bus.PCSource  = pcSource  & RST_N;
    assign bus.PCAdd     = pcAdd     & RST_N;
    assign bus.MSPWrite  = mspWrite  & RST_N;
    assign bus.MSPPop    = mspPop    & RST_N;
    assign bus.RSPWrite  = rspWrite  & RST_N;
    assign bus.RSPPop    = rspPop    & RST_N;
    assign bus.ValAWrite = valAWrite & RST_N;
    assign bus.ValBWrite = valBWrite & RST_N;
    assign bus.IRWrite   = irWrite   & RST_N;
    assign bus.MemRead1  = memRead1  & RST_N;
    assign bus.MemRead2  = memRead2  & RST_N;
    assign bus.MemWrite1 = memWrite1 & RST_N;
    assign bus.MemWrite2 = memWrite2 & RST_N;
    assign bus.MemDst1   = memDst1   & {2{RST_N}};
    assign bus.MemDst2   = memDst2   & {2{RST_N}};
    assign bus.MemData   = memData   & {3{RST_N}};
    assign bus.InstrDone = instrDone & RST_N;
    assign bus.Halted    = halted    & RST_N;

endmodule
